// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle for rr_stream_arbiter: N request streams in, one arbitrated stream out.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface rr_stream_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SRCW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SRCW-1:0]    out_src;
  logic               out_ready;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding a single registered valid/ready output stage.
// A grant is held from a packet's first accepted beat until its last beat is accepted.
module rr_stream_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic            clk,
  input logic            rstn,
  rr_stream_arbiter_if.master bus
);
  localparam int SRCW = $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  logic [SRCW-1:0]   ptr_r;
  logic [SRCW-1:0]   gnt_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              out_last_r;
  logic [SRCW-1:0]   out_src_r;

  logic [SRCW-1:0]   idx_s;
  logic [SRCW-1:0]   pick_s;
  logic              found_s;
  logic              hit_s;
  logic [SRCW-1:0]   k_s;
  logic              req_s;
  logic              stage_free_s;
  logic [N-1:0]      ready_s;
  logic              accept_s;
  logic [WIDTH-1:0]  data_k_s;
  logic              last_k_s;
  logic [SRCW-1:0]   next_ptr_s;

  function automatic logic [SRCW-1:0] wrap_add(input logic [SRCW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return s[SRCW-1:0];
  endfunction

  // Rotating-priority search for the first valid requester starting at ptr.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s   = wrap_add(ptr_r, i);
      hit_s   = !found_s && bus.in_valid[idx_s];
      pick_s  = hit_s ? idx_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  assign k_s          = (state_r == LOCKED) ? gnt_r : pick_s;
  assign req_s        = (state_r == LOCKED) | found_s;
  assign stage_free_s = ~out_valid_r | bus.out_ready;

  // Only the granted (or picked) requester may see ready, and only while the stage can take a beat.
  always_comb begin
    ready_s = '0;
    if (rstn && req_s && stage_free_s) begin
      ready_s[k_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s   = bus.in_valid[k_s] & ready_s[k_s];
  assign data_k_s   = bus.in_data[int'(k_s)*WIDTH +: WIDTH];
  assign last_k_s   = bus.in_last[k_s];
  assign next_ptr_s = wrap_add(k_s, 1);

  // Arbitration state and output stage; ptr moves only when a packet closes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gnt_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_src_r   <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_k_s;
      out_last_r  <= last_k_s;
      out_src_r   <= k_s;
      case (state_r)
        IDLE: begin
          if (last_k_s) begin
            ptr_r <= next_ptr_s;
          end else begin
            state_r <= LOCKED;
            gnt_r   <= k_s;
          end
        end
        LOCKED: begin
          if (last_k_s) begin
            state_r <= IDLE;
            ptr_r   <= next_ptr_s;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_src   = out_src_r;
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: expected beats are queued as stimulus is driven
// and compared as the output stage pops them.
module tb_rr_stream_arbiter;
  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic clk;
  logic rstn;
  int   checks;
  int   passes;
  logic [34:0] exp_q[$];

  rr_stream_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  rr_stream_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_beat(input int i, input logic [31:0] d, input logic l);
    bus.in_data[i*WIDTH +: WIDTH] = d;
    bus.in_last[i] = l;
  endtask

  task automatic push(input int s, input logic l, input logic [31:0] d);
    logic [1:0] sv;
    sv = s[1:0];
    exp_q.push_back({sv, l, d});
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every beat popped by downstream must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $error("FAIL sb_underflow observed=%h expected=none",
               {bus.out_src, bus.out_last, bus.out_data});
      end else begin
        chk("sb_beat", {29'd0, bus.out_src, bus.out_last, bus.out_data}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int pk;
    checks = 0;
    passes = 0;
    rstn = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = '0;
    bus.in_last   = 4'h0;
    bus.out_ready = 1'b0;
    #1 rstn = 1'b0;

    // reset state, with requests pending
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data",  bus.out_data,  32'd0);
    chk("rst_out_last",  bus.out_last,  1'b0);
    chk("rst_out_src",   bus.out_src,   2'd0);
    chk("rst_in_ready",  bus.in_ready,  4'h0);
    next_drive();
    rstn = 1'b1;
    bus.in_valid = 4'h0;

    // single beat from req0
    next_drive();
    set_beat(0, 32'hA5A5_0001, 1'b1);
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    push(0, 1'b1, 32'hA5A5_0001);
    @(negedge clk);
    chk("single_ready", bus.in_ready, 4'b0001);
    next_drive();

    // round robin, all requesters offering single-beat packets; ptr starts at 1
    bus.in_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        set_beat(i, {i[7:0], c[23:0]}, 1'b1);
      end
      pk = (1 + c) % N;
      push(pk, 1'b1, {pk[7:0], c[23:0]});
      @(negedge clk);
      chk("rr_ready", bus.in_ready, 4'b0001 << pk);
      chk("rr_no_bubble", bus.out_valid, 1'b1);
      next_drive();
    end

    // packet lock: req1 sends 3 beats while req0/req2 wait; ptr = 1
    bus.in_valid = 4'b0111;
    set_beat(0, 32'h0D00_0000, 1'b1);
    set_beat(1, 32'h1111_0001, 1'b0);
    set_beat(2, 32'h2D00_0000, 1'b1);
    push(1, 1'b0, 32'h1111_0001);
    @(negedge clk);
    chk("lock_beat1_ready", bus.in_ready, 4'b0010);
    next_drive();
    bus.in_valid = 4'b0101;
    @(negedge clk);
    chk("lock_gap_ready", bus.in_ready, 4'b0010);
    next_drive();
    bus.in_valid = 4'b0111;
    set_beat(1, 32'h1111_0002, 1'b0);
    push(1, 1'b0, 32'h1111_0002);
    @(negedge clk);
    chk("lock_beat2_ready", bus.in_ready, 4'b0010);
    next_drive();
    set_beat(1, 32'h1111_0003, 1'b1);
    push(1, 1'b1, 32'h1111_0003);
    @(negedge clk);
    chk("lock_beat3_ready", bus.in_ready, 4'b0010);
    next_drive();
    push(2, 1'b1, 32'h2D00_0000);
    @(negedge clk);
    chk("unlock_next_ready", bus.in_ready, 4'b0100);
    next_drive();

    // drain
    bus.in_valid = 4'h0;
    @(negedge clk);
    chk("drain_valid_last", bus.out_valid, 1'b1);
    chk("drain_ready", bus.in_ready, 4'h0);
    next_drive();
    @(negedge clk);
    chk("drain_valid_low", bus.out_valid, 1'b0);
    chk("drain_data_hold", bus.out_data, 32'h2D00_0000);
    chk("drain_src_hold", bus.out_src, 2'd2);
    chk("drain_ready_idle", bus.in_ready, 4'h0);
    next_drive();

    // backpressure; ptr = 3 so the search wraps to req0
    bus.in_valid = 4'b0001;
    set_beat(0, 32'hB000_0001, 1'b1);
    push(0, 1'b1, 32'hB000_0001);
    @(negedge clk);
    chk("bp_wrap_ready", bus.in_ready, 4'b0001);
    next_drive();
    set_beat(0, 32'hB000_0002, 1'b1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data",  bus.out_data,  32'hB000_0001);
      chk("bp_src",   bus.out_src,   2'd0);
      chk("bp_ready", bus.in_ready,  4'h0);
      next_drive();
    end
    bus.out_ready = 1'b1;
    push(0, 1'b1, 32'hB000_0002);
    @(negedge clk);
    chk("bp_release_ready", bus.in_ready, 4'b0001);
    next_drive();
    bus.in_valid = 4'h0;
    @(negedge clk);
    chk("bp_reload_valid", bus.out_valid, 1'b1);
    next_drive();

    // reset during beat 2 of a req3 packet; ptr = 1
    bus.in_valid = 4'b1000;
    set_beat(3, 32'h3333_0001, 1'b0);
    push(3, 1'b0, 32'h3333_0001);
    @(negedge clk);
    chk("rstmid_ready", bus.in_ready, 4'b1000);
    next_drive();
    set_beat(3, 32'h3333_0002, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_valid", bus.out_valid, 1'b0);
    chk("rstmid_in_ready", bus.in_ready, 4'h0);
    chk("rstmid_src", bus.out_src, 2'd0);
    bus.in_valid = 4'h0;
    next_drive();
    rstn = 1'b1;
    next_drive();
    bus.in_valid = 4'b1001;
    set_beat(0, 32'h0000_00C0, 1'b1);
    set_beat(3, 32'h3333_0003, 1'b1);
    push(0, 1'b1, 32'h0000_00C0);
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 4'b0001);
    next_drive();
    bus.in_valid = 4'h0;
    @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 1'b1);
    next_drive();
    @(negedge clk);
    chk("final_valid", bus.out_valid, 1'b0);
    chk("sb_empty", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
